// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the byte-lane RAM controller.
package ram_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/ram_lane_sp.sv
// One byte lane of the data RAM: single write port plus a synchronous read port.
// The array itself carries no reset so it maps onto block RAM.
module ram_lane_sp
  import ram_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);
  logic [BYTE_W-1:0] mem_q [2**AW];
  logic [BYTE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/byte_ram_ctrl.sv
// Byte-lane data RAM with valid/ready request/response handshakes and a one-slot response register.
// Define RAM_INIT_EN to zero the whole array after every reset before requests are accepted.
module byte_ram_ctrl
  import ram_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 12,
  parameter int OFF = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [DW/BYTE_W-1:0] req_be,
  input  logic [31:0]          req_addr,
  input  logic [DW-1:0]        req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 rsp_err
);
  localparam int NB = DW / BYTE_W;

`ifdef RAM_INIT_EN
  localparam state_e RESET_STATE = INIT;
  localparam logic [AW-1:0] LAST_IDX = '1;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  state_e          state_q, state_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [AW-1:0]   idx;
  logic            oor, accept, rd_en, wr_en;
  logic [NB-1:0]   lane_we;
  logic [AW-1:0]   lane_waddr;
  logic [DW-1:0]   lane_wdata;
  logic [DW-1:0]   ram_rdata;
`ifdef RAM_INIT_EN
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RESET_STATE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
`ifdef RAM_INIT_EN
    if (state_q == INIT && init_cnt_q == LAST_IDX) state_d = RUN;
`else
    state_d = RUN;
`endif
  end

  // Output logic: a drained response slot can be refilled in the same cycle
  always_comb begin
    req_ready = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
  end

  always_comb begin
    idx    = req_addr[OFF+AW-1:OFF];
    oor    = (req_addr >> (OFF + AW)) != 32'd0;
    accept = req_valid && req_ready;
    rd_en  = accept && !req_we;
    wr_en  = accept && req_we && !oor;

    lane_we    = wr_en ? req_be : '0;
    lane_waddr = idx;
    lane_wdata = req_wdata;
`ifdef RAM_INIT_EN
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      lane_we    = '1;
      lane_waddr = init_cnt_q;
      lane_wdata = '0;
      init_cnt_d = init_cnt_q + 1'b1;
    end
`endif

    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    if (rd_en) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = oor;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef RAM_INIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) init_cnt_q <= '0;
    else      init_cnt_q <= init_cnt_d;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      ram_lane_sp #(.AW(AW)) u_lane (
        .clk   (clk),
        .we    (lane_we[gi]),
        .waddr (lane_waddr),
        .wdata (lane_wdata[gi*BYTE_W +: BYTE_W]),
        .re    (rd_en),
        .raddr (idx),
        .rdata (ram_rdata[gi*BYTE_W +: BYTE_W])
      );
    end
  endgenerate

  // Lane read registers are not reset, so data is gated to zero unless a valid in-range response is held
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && !rsp_err_q) ? ram_rdata : '0;
endmodule

// File: doc/byte_ram_ctrl.md
Name: byte_ram_ctrl

Overview:
- Parametrised byte-lane data RAM with a valid/ready request/response interface. Successor to the fixed 32-bit, 4096-word byte-lane RAM.
- Generalised data width (any multiple of 8), depth and address base.
- Adds back-pressure, registered read responses, out-of-range error reporting, and an optional post-reset memory-clear sequencer.
- Sits between the core LSU / bus fabric and on-chip data storage.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8; NB = DW/8 byte lanes (derived).
- AW, 12, word-address width; depth = 2**AW words.
- OFF, 2, byte-offset bits dropped from req_addr; must equal log2(NB).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  NB  byte-lane write enables (ignored for reads).
- req_addr  in  32  byte address.
- req_wdata  in  DW  write data; lane i = bits [8i+7:8i].
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DW  read data.
- rsp_err  out  1  read address was out of range.

Behaviour:
- Reset: rst asserted asynchronously forces rsp_valid=0, rsp_err=0, rsp_rdata=0 and FSM to its reset state. Memory contents are not cleared by reset itself.
- Word index = req_addr[OFF+AW-1:OFF]. The access is out-of-range if req_addr[31:OFF+AW] != 0.
- Accept = req_valid && req_ready.
- req_ready = (state==RUN) && (!rsp_valid || rsp_ready). This is a single response slot with same-cycle pass-through of a drained slot.
- Accepted write: each lane i with req_be[i]=1 is written at that clock edge.
  - No response is produced.
  - An out-of-range write is silently dropped; no lane is written.
  - req_be=0 is a legal no-op.
- Accepted read: exactly 1 cycle latency.
  - rsp_valid=1 on the next cycle, with rsp_rdata = the word at that index.
  - If out-of-range: rsp_rdata=0 and rsp_err=1.
- Response hold: while rsp_valid && !rsp_ready, rsp_rdata and rsp_err stay stable and the RAM read enable is held low.
- Response completion: rsp_valid clears on rsp_ready unless a new read is accepted in the same cycle.
- Read-after-write at the same index in the next cycle returns the new data, because the write commits before the read edge.
- Reads are issued only on accept, so a pending response is never corrupted by later writes.
- FSM states: INIT (clearing), RUN.
  - Without RAM_INIT_EN, reset enters RUN directly.
- Reset mid-operation: a pending response is discarded. Any in-progress INIT restarts from index 0 on release.

Optional Feature:
- Macro RAM_INIT_EN.
- Defined:
  - Reset enters INIT with init_cnt=0 and req_ready=0.
  - Each cycle, all lanes are written with 0 at index init_cnt, then init_cnt increments.
  - When init_cnt reaches 2**AW-1 and that word has been written, the FSM moves to RUN.
  - INIT lasts exactly 2**AW cycles.
  - Requests asserted during INIT are stalled, not lost.
- Not defined:
  - No INIT state and no counter; RUN immediately after reset.
  - Memory is uninitialised (X in simulation).

Decomposition:
- Package ram_pkg: BYTE_W=8 constant; state typedef enum {INIT, RUN}.
- Sub-module ram_lane_sp: 8-bit wide, 2**AW deep, one write port plus one synchronous-read port, no reset on the array. NB instances are created by a generate loop.
- The top level holds the FSM, init counter, handshake logic and response register.

Test Plan:
- Reset release (DW=32, AW=4, macro off) -> req_ready=1 on the first cycle after rst deasserts. Write 0xDEADBEEF to 0x08 with be=4'hF, then read 0x08 -> rsp_valid one cycle later with rsp_rdata=0xDEADBEEF and rsp_err=0.
- Partial write: write 0x11223344 to 0x08 with be=4'b0101, then read -> rsp_rdata=0xDE22BE44.
- Back-pressure: read 0x08 with rsp_ready held 0 for 3 cycles, while a write to 0x08 is attempted -> req_ready=0, rsp_rdata stable at 0xDE22BE44 throughout. After rsp_ready=1 the write is accepted.
- Out-of-range (AW=4): read addr 0x40 -> rsp_err=1, rsp_rdata=0. Write 0xFFFFFFFF to 0x40, then read 0x00 -> original value unchanged.
- Back-to-back reads at 0x00, 0x04, 0x08 with rsp_ready=1 -> one response per cycle, in order, with no bubbles.
- RAM_INIT_EN, AW=4, DW=64 -> req_ready=0 for exactly 16 cycles after reset. Then a read of any index returns 0. Asserting rst at cycle 7 of INIT restarts the 16-cycle count.
